// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter
// Round-robin arbiter and sequencer that shares one registered arithmetic
// resource (for example a residue-digit MAC slice) among N_REQ requesters.
// Flow: IDLE -> GRANT (start strobe) -> WAIT (for res_done) -> DONE (done pulse).
// All outputs are registered.
// Optional WAIT-state watchdog: define ARB_TIMEOUT_EN. When it is undefined,
// no counter is built and err is tied to 0.
module rr_resource_arbiter #(
   parameter int N_REQ   = 4,
   parameter int IDX_W   = 2,
   parameter int TMO_CYC = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic             start,
   output logic [IDX_W-1:0] sel,
   input  logic             res_done,
   output logic [N_REQ-1:0] done,
   output logic             err,
   output logic             busy
);

   // Stop elaboration if the parameters cannot describe a legal arbiter.
   if (N_REQ < 2 || N_REQ > 16 || (1 << IDX_W) < N_REQ || TMO_CYC < 1) begin : g_bad_params
      $error("rr_resource_arbiter: illegal N_REQ/IDX_W/TMO_CYC combination");
   end

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      WAIT,
      DONE
   } state_t;

   localparam logic [N_REQ-1:0] ONE   = N_REQ'(1);
   localparam logic [IDX_W:0]   N_EXT = (IDX_W + 1)'(N_REQ);
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ - 1);

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] win;
   logic             win_vld;
   logic [IDX_W:0]   cand;

`ifdef ARB_TIMEOUT_EN
   localparam int             CNT_W    = $clog2(TMO_CYC + 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

   logic [CNT_W-1:0] tmo_cnt;
`else
   assign err = 1'b0;
`endif

   // Winner search: first set request scanning ptr, ptr+1, ... with wrap at N_REQ.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         cand = {1'b0, ptr} + (IDX_W + 1)'(i);
         if (cand >= N_EXT) begin
            cand = cand - N_EXT;
         end
         if (!win_vld && req[cand[IDX_W-1:0]]) begin
            win     = cand[IDX_W-1:0];
            win_vld = 1'b1;
         end
      end
   end

   // Sequencer FSM with registered outputs; outputs reflect the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         sel   <= '0;
         gnt   <= '0;
         start <= 1'b0;
         done  <= '0;
         busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         err     <= 1'b0;
         tmo_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (win_vld) begin
                  state <= GRANT;
                  sel   <= win;
                  gnt   <= ONE << win;
                  start <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            GRANT: begin
               // res_done is not looked at here: the resource needs at least one cycle.
               state <= WAIT;
               gnt   <= '0;
               start <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT: begin
`ifdef ARB_TIMEOUT_EN
               // res_done takes priority over a watchdog expiry on the same edge.
               tmo_cnt <= tmo_cnt + CNT_W'(1);
               if (res_done) begin
                  state <= DONE;
                  done  <= ONE << sel;
               end else if (tmo_cnt == TMO_LAST) begin
                  state <= DONE;
                  done  <= ONE << sel;
                  err   <= 1'b1;
               end
`else
               if (res_done) begin
                  state <= DONE;
                  done  <= ONE << sel;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
               done  <= '0;
               busy  <= 1'b0;
               // Explicit wrap so non-power-of-two N_REQ never points past the last requester.
               ptr   <= (sel == LAST) ? '0 : sel + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
               err   <= 1'b0;
`endif
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Testbench for rr_resource_arbiter: a 4-requester instance drives most of the
// checks, a 3-requester instance covers the non-power-of-two pointer wrap.
module tb_rr_resource_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       res_done;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [3:0] done;
   logic [1:0] sel;
   logic       start;
   logic       err;
   logic       busy;

   logic [2:0] req3;
   logic [2:0] gnt3;
   logic [2:0] done3;
   logic [1:0] sel3;
   logic       start3;
   logic       err3;
   logic       busy3;

   rr_resource_arbiter #(.N_REQ(4), .IDX_W(2), .TMO_CYC(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .start   (start),
      .sel     (sel),
      .res_done(res_done),
      .done    (done),
      .err     (err),
      .busy    (busy)
   );

   rr_resource_arbiter #(.N_REQ(3), .IDX_W(2), .TMO_CYC(8)) dut3 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req3),
      .gnt     (gnt3),
      .start   (start3),
      .sel     (sel3),
      .res_done(res_done),
      .done    (done3),
      .err     (err3),
      .busy    (busy3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Operation tasks look at whichever instance is selected by use3.
   logic       use3 = 1'b0;
   logic [3:0] v_gnt;
   logic [3:0] v_done;
   logic [1:0] v_sel;
   logic       v_start;
   logic       v_err;
   logic       v_busy;

   always_comb begin
      v_gnt   = use3 ? {1'b0, gnt3}  : gnt;
      v_done  = use3 ? {1'b0, done3} : done;
      v_sel   = use3 ? sel3   : sel;
      v_start = use3 ? start3 : start;
      v_err   = use3 ? err3   : err;
      v_busy  = use3 ? busy3  : busy;
   end

   int exp_gnt_q[$];
   int exp_done_q[$];
   int last_sel;

   typedef struct {
      logic [3:0] r;
      int         lat;
      int         w;
   } vec_t;

   vec_t tbl[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   // Structural invariants sampled on every falling edge outside reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check("inv_start_eq_or_gnt", start, |gnt);
         check("inv_gnt_onehot0", $onehot0(gnt), 1);
         check("inv_done_onehot0", $onehot0(done), 1);
         check("inv_sel_known", $isunknown(sel), 0);
         check("inv3_start_eq_or_gnt", start3, |gnt3);
         check("inv3_done_onehot0", $onehot0(done3), 1);
      end
   end

   // One full operation starting from an IDLE-cycle falling edge; ends on the next IDLE falling edge.
   task automatic do_op(input logic [3:0] r, input int lat, input int exp_w,
                        input bit drop_in_wait, input bit early_rd, input bit no_rd);
      int busy_cnt;
      int w;
      if (use3) req3 = r[2:0];
      else      req  = r;
      exp_gnt_q.push_back(exp_w);
      @(negedge clk);
      busy_cnt = int'(v_busy);
      w = exp_gnt_q.pop_front();
      check("grant_gnt", v_gnt, oh(w));
      check("grant_sel", v_sel, w);
      check("grant_start", v_start, 1);
      last_sel = int'(v_sel);
      if (early_rd) res_done = 1'b1;
      for (int c = 1; c <= lat; c++) begin
         @(negedge clk);
         res_done = 1'b0;
         busy_cnt += int'(v_busy);
         check("wait_gnt", v_gnt, 0);
         check("wait_start", v_start, 0);
         check("wait_done", v_done, 0);
         check("wait_sel", v_sel, exp_w);
         if (c == 1 && drop_in_wait) begin
            if (use3) req3 = '0;
            else      req  = '0;
         end
         if (c == lat) begin
            if (!no_rd) res_done = 1'b1;
            exp_done_q.push_back(exp_w);
         end
      end
      @(negedge clk);
      res_done = 1'b0;
      busy_cnt += int'(v_busy);
      w = exp_done_q.pop_front();
      check("done_pulse", v_done, oh(w));
      check("done_err", v_err, no_rd);
      check("done_sel", v_sel, w);
      check("done_gnt", v_gnt, 0);
      @(negedge clk);
      check("idle_busy", v_busy, 0);
      check("idle_done", v_done, 0);
      check("idle_err", v_err, 0);
      check("busy_cycles", busy_cnt, lat + 2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Sequential operations from reset (ptr=0); winners derived by hand.
      tbl[0]  = '{4'b1111, 1, 0};
      tbl[1]  = '{4'b0001, 2, 0};
      tbl[2]  = '{4'b1001, 1, 3};
      tbl[3]  = '{4'b1001, 3, 0};
      tbl[4]  = '{4'b0110, 1, 1};
      tbl[5]  = '{4'b0011, 2, 0};
      tbl[6]  = '{4'b1100, 4, 2};
      tbl[7]  = '{4'b0100, 1, 2};
      tbl[8]  = '{4'b1111, 2, 3};
      tbl[9]  = '{4'b1010, 1, 1};
      tbl[10] = '{4'b1000, 3, 3};

      rst_n    = 1'b0;
      res_done = 1'b0;
      req      = 4'b1111;
      req3     = 3'b111;
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_start", start, 0);
      check("rst_sel", sel, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      check("rst3_gnt", gnt3, 0);
      check("rst3_busy", busy3, 0);
      req3  = '0;
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         do_op(tbl[i].r, tbl[i].lat, tbl[i].w, 1'b0, 1'b0, 1'b0);
      end

      // Single request, resource latency 5: busy for 7 cycles.
      do_op(4'b0100, 5, 2, 1'b0, 1'b0, 1'b0);
      do_op(4'b1000, 1, 3, 1'b0, 1'b0, 1'b0);

      // All requesters held: rotation 0,1,2,3,0, never the same twice in a row.
      last_sel = 3;
      for (int k = 0; k < 5; k++) begin
         int prev;
         prev = last_sel;
         do_op(4'b1111, 2, k % 4, 1'b0, 1'b0, 1'b0);
         check("rr_no_repeat", last_sel != prev, 1);
      end

      // Requester drops its request during WAIT; done still arrives.
      do_op(4'b0010, 3, 1, 1'b1, 1'b0, 1'b0);

      // Spurious res_done in IDLE.
      req      = '0;
      res_done = 1'b1;
      @(negedge clk);
      res_done = 1'b0;
      check("spur_idle_done", done, 0);
      check("spur_idle_busy", busy, 0);
      @(negedge clk);
      check("spur_idle_done2", done, 0);
      check("spur_idle_gnt", gnt, 0);

      // res_done during the GRANT cycle is ignored.
      do_op(4'b0001, 3, 0, 1'b0, 1'b1, 1'b0);

      // res_done on the 8th WAIT cycle: completes without err.
      do_op(4'b0100, 8, 2, 1'b0, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
      // No res_done: watchdog ends WAIT after 8 cycles with err.
      do_op(4'b0001, 8, 0, 1'b0, 1'b0, 1'b1);
`else
      // No watchdog: WAIT outlasts 8 cycles until res_done.
      do_op(4'b0001, 12, 0, 1'b0, 1'b0, 1'b0);
`endif

      // Asynchronous reset in WAIT abandons the operation (ptr=1 beforehand).
      req = 4'b1000;
      @(negedge clk);
      check("prerst_gnt", gnt, 4'b1000);
      @(negedge clk);
      check("prerst_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_gnt", gnt, 0);
      check("arst_start", start, 0);
      check("arst_sel", sel, 0);
      check("arst_done", done, 0);
      check("arst_err", err, 0);
      check("arst_busy", busy, 0);
      @(negedge clk);
      check("arst_hold_done", done, 0);
      rst_n = 1'b1;
      do_op(4'b0011, 2, 0, 1'b0, 1'b0, 1'b0);
      do_op(4'b0010, 1, 1, 1'b0, 1'b0, 1'b0);
      req = '0;

      // Three requesters: explicit pointer wrap after index 2.
      use3 = 1'b1;
      do_op(4'b0100, 1, 2, 1'b0, 1'b0, 1'b0);
      do_op(4'b0101, 2, 0, 1'b0, 1'b0, 1'b0);
      do_op(4'b0101, 1, 2, 1'b0, 1'b0, 1'b0);
      do_op(4'b0111, 1, 0, 1'b0, 1'b0, 1'b0);
      do_op(4'b0111, 1, 1, 1'b0, 1'b0, 1'b0);
      do_op(4'b0111, 1, 2, 1'b0, 1'b0, 1'b0);
      do_op(4'b0111, 1, 0, 1'b0, 1'b0, 1'b0);
      req3 = '0;
      use3 = 1'b0;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_resource_arbiter.md
Name: rr_resource_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one registered arithmetic resource among N_REQ requesters in the TPU datapath. Example resources: a residue-digit MAC slice or a normalization/gating stage.
- Selects a requester and drives the resource's operand-select and start strobe.
- Waits for the resource's completion, then returns a per-requester done pulse.
- All outputs are registered.

Parameters:
- N_REQ, 4, number of requesters; any value 2..16, power of two not required.
- IDX_W, 2, width of the select index; must satisfy 2**IDX_W >= N_REQ.
- TMO_CYC, 64, watchdog limit in cycles for the WAIT state; used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N_REQ  level request per requester; held high until the matching done pulse.
- gnt  out  N_REQ  one-hot grant; high for exactly one cycle per operation.
- start  out  1  one-cycle start strobe to the resource; coincident with gnt.
- sel  out  IDX_W  index of the granted requester; stable from the grant cycle through the done cycle.
- res_done  in  1  resource completion strobe.
- done  out  N_REQ  one-hot completion pulse to the granted requester.
- err  out  1  timeout flag; pulses with done. Tied 0 when ARB_TIMEOUT_EN is undefined.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ptr=0.
  - gnt=0, start=0, sel=0, done=0, err=0, busy=0.
  - Reset mid-operation abandons the operation silently; no done pulse is issued.
- States: IDLE, GRANT, WAIT, DONE.
- IDLE:
  - If req is nonzero at an edge, pick winner w as the first set bit scanning ptr, ptr+1, ... with wrap modulo N_REQ.
  - Register sel=w; next state GRANT.
  - If req is zero, stay in IDLE.
- GRANT (exactly 1 cycle):
  - gnt[w]=1, start=1, busy=1; next state WAIT.
  - res_done in this cycle is ignored; the resource's minimum latency is 1 cycle.
- WAIT:
  - Hold sel; gnt=0, start=0.
  - On res_done=1, next state DONE.
- DONE (exactly 1 cycle):
  - done[w]=1.
  - ptr <= (w+1) mod N_REQ; the wrap is explicit for non-power-of-two N_REQ.
  - Next state IDLE.
- Latency:
  - req rising at edge k gives gnt/start high during cycle k+1.
  - res_done sampled at edge m gives done high during cycle m+1.
  - Minimum request-to-done time is 3 cycles. Back-to-back throughput is one operation per (resource latency + 3) cycles.
- Requester behaviour during an operation:
  - Dropping req during GRANT or WAIT does not cancel the operation; done still pulses.
  - A new req from any requester while busy waits for IDLE.
- Fairness:
  - The requester granted last has lowest priority next.
  - With all requesters active, the grant order is 0,1,2,3,0,...
- Invariants:
  - gnt and done are always one-hot or zero.
  - start == |gnt.
  - sel is never X after reset.
- Spurious res_done in IDLE or DONE is ignored.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter of width clog2(TMO_CYC+1) clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches TMO_CYC without res_done, the arbiter goes to DONE and pulses done[w] and err together for 1 cycle. ptr advances normally.
  - If res_done arrives on the same edge the count reaches TMO_CYC, res_done wins and err=0.
- Undefined: no counter is built, err is constant 0, and WAIT lasts indefinitely.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 immediately (asynchronous); after release, req=4'b0010 -> gnt=4'b0010, sel=1 one cycle later.
- Single request: req=4'b0100, resource latency 5 -> start/gnt[2] 1 cycle; done[2] exactly 1 cycle after res_done; busy high for 7 cycles.
- Round-robin: req=4'b1111 held, res_done 2 cycles after start -> grant order 0,1,2,3,0; no requester is granted twice in a row.
- Wrap with N_REQ=3: last grant 2, req=3'b101 -> next grant index 0, then 2.
- Robustness: drop req[1] during WAIT -> done[1] still pulses; res_done pulse in IDLE -> no done; res_done in GRANT cycle -> ignored, still waits.
- ARB_TIMEOUT_EN with TMO_CYC=8, res_done never arrives -> done[w] and err pulse together, 8 cycles after WAIT entry. A second run with res_done on the 8th cycle -> err=0.
